// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the I-fetch fill path and the
// D path (block fills and write-through stores). D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LAT     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic                           i_fill_valid,
    output logic                           d_fill_valid,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W:0]   ISS_END  = (IDX_W+1)'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_d_q;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W:0]      iss_cnt_q;
    logic [IDX_W-1:0]    ret_cnt_q;
    logic                mem_en_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [IDX_W-1:0]    fill_idx_q;
    logic [DATA_W-1:0]   fill_hold_q;
    logic                i_fv_q;
    logic                d_fv_q;
    logic                i_done_q;
    logic                d_done_q;

    logic                rd_issue;
    logic                ret_next;
    logic [ADDR_W-1:0]   req_addr_d;
    logic [ADDR_W-1:0]   req_base_d;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(2 * BLOCK_WORDS - 1);
    endfunction

    assign rd_issue   = mem_en_q & ~mem_wr_q;
    assign req_addr_d = d_req ? d_addr : i_addr;
    assign req_base_d = block_base(req_addr_d);

    // ret_next is high one cycle before a word's latency elapses, so the
    // valid/idx registers line up exactly with mem_rdata.
    if (MEM_LAT == 1) begin : g_lat1
        assign ret_next = rd_issue;
    end else begin : g_latn
        logic [MEM_LAT-2:0] lat_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                lat_q <= '0;
            end else begin
                lat_q <= (lat_q << 1) | (MEM_LAT-1)'(rd_issue);
            end
        end
        assign ret_next = lat_q[MEM_LAT-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            base_q      <= '0;
            iss_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_idx_q  <= '0;
            fill_hold_q <= '0;
            i_fv_q      <= 1'b0;
            d_fv_q      <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            i_fv_q      <= 1'b0;
            d_fv_q      <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            fill_hold_q <= fill_data;

            if (ret_next) begin
                fill_idx_q <= ret_cnt_q;
                ret_cnt_q  <= ret_cnt_q + IDX_W'(1);
                i_fv_q     <= ~owner_d_q;
                d_fv_q     <= owner_d_q;
                if (ret_cnt_q == LAST_IDX) begin
                    i_done_q <= ~owner_d_q;
                    d_done_q <= owner_d_q;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (d_req && d_wr) begin
                        state_q     <= WRITE;
                        owner_d_q   <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= d_addr & ~ADDR_W'(1);
                        mem_wdata_q <= d_wdata;
                        d_done_q    <= 1'b1;
                    end else if (d_req || i_req) begin
                        // Word 0 is issued straight out of IDLE; FILL issues the rest.
                        state_q    <= FILL;
                        owner_d_q  <= d_req;
                        base_q     <= req_base_d;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= req_base_d;
                        iss_cnt_q  <= (IDX_W+1)'(1);
                    end
                end
                FILL: begin
                    if (iss_cnt_q != ISS_END) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= base_q + ADDR_W'({iss_cnt_q[IDX_W-1:0], 1'b0});
                        iss_cnt_q  <= iss_cnt_q + (IDX_W+1)'(1);
                    end
                    if (i_done_q || d_done_q) begin
                        state_q   <= IDLE;
                        iss_cnt_q <= '0;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Returned words pass straight through; the held copy covers non-valid cycles.
    assign fill_data    = (i_fv_q || d_fv_q) ? mem_rdata : fill_hold_q;
    assign fill_idx     = fill_idx_q;
    assign i_fill_valid = i_fv_q;
    assign d_fill_valid = d_fv_q;
    assign i_done       = i_done_q;
    assign d_done       = d_done_q;
    assign mem_en       = mem_en_q;
    assign mem_wr       = mem_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port, fixed-latency main memory between the instruction-fetch miss path (I) and the data-access path (D). It sequences pipelined block fills of BLOCK_WORDS words into the requesting cache and single-word write-through stores from D. It sits between the I/D cache controllers and the main memory model, and stalls the pipeline via busy and the per-side done pulses.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, word width
MEM_LAT, 4, cycles from a read issue (mem_en=1, mem_wr=0) to valid mem_rdata; legal range >=1
BLOCK_WORDS, 8, words per fill; power of two; byte stride 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
i_req  in  1  I-side fill request; held until i_done
i_addr  in  ADDR_W  I-side miss address; stable while i_req=1
d_req  in  1  D-side request; held until d_done
d_wr  in  1  1 = single-word store, 0 = block fill
d_addr  in  ADDR_W  D-side address
d_wdata  in  DATA_W  store data
mem_en  out  1  memory access strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after issue
fill_data  out  DATA_W  returned word (shared by both sides)
fill_idx  out  log2(BLOCK_WORDS)  word index within the block
i_fill_valid  out  1  fill_data/fill_idx valid for I
d_fill_valid  out  1  fill_data/fill_idx valid for D
i_done  out  1  one-cycle pulse, I transaction complete
d_done  out  1  one-cycle pulse, D transaction complete
busy  out  1  high in any non-IDLE state

Behaviour:
- Reset (sync, rst=1 at an edge): next cycle state=IDLE, counters=0; all outputs 0, including mem_addr, fill_data and fill_idx.
- States: IDLE, FILL, WRITE. Requests are sampled only in IDLE. Priority is fixed: D over I. A losing I request waits; it is re-sampled in the next IDLE cycle.
- IDLE -> WRITE when d_req & d_wr. IDLE -> FILL when d_req & ~d_wr (owner=D), else when i_req (owner=I). The address and owner are latched at the transition.
- Block base = latched address with bits [log2(BLOCK_WORDS):0] cleared.
- FILL:
  - issue counter k=0..BLOCK_WORDS-1, one per cycle: mem_en=1, mem_wr=0, mem_addr=base+2k.
  - A return counter tracks words whose latency has elapsed. The word issued at cycle c appears as fill_data at c+MEM_LAT with fill_idx=k, and the owner's fill_valid is set.
  - Issue and return overlap; there are no bubbles.
  - The owner's done pulses in the same cycle as the word with idx BLOCK_WORDS-1. The next cycle is IDLE.
- Fill timing: request seen in IDLE at cycle T. Issues occur at T+1..T+BLOCK_WORDS. Data returns at T+1+MEM_LAT..T+BLOCK_WORDS+MEM_LAT. Done occurs at T+BLOCK_WORDS+MEM_LAT. IDLE follows at the next cycle.
- Address arithmetic is modulo 2^ADDR_W. Since the base is block-aligned, a block never crosses a wrap.
- WRITE (one cycle): mem_en=1, mem_wr=1, mem_addr=latched d_addr with bit0 cleared, mem_wdata=latched d_wdata. d_done pulses in this cycle; next cycle is IDLE. The memory commits the write at this edge.
- Outputs are 0 whenever not driven: mem_en/mem_wr outside issue cycles, fill_valid outside return cycles, done except the final cycle. fill_data and fill_idx hold their last value when no valid is asserted.
- Never assert i_fill_valid and d_fill_valid together. Never assert i_done and d_done in the same cycle.
- Dropping a request mid-transaction is illegal. The arbiter completes the transaction regardless.
- rst mid-transaction: IDLE next cycle. Words still in flight in memory are discarded, and no valid or done is produced for them.
- Requests still high in the IDLE cycle after done are accepted immediately. Minimum back-to-back spacing is one IDLE cycle.

Test Plan:
- Reset, then idle with no requests -> all outputs 0 and busy=0 for 10 cycles.
- i_req, i_addr=0x1234 at T -> mem_addr 0x1230..0x123E at T+1..T+8; i_fill_valid at T+5..T+12 with idx 0..7 matching the memory image; i_done at T+12; busy=0 at T+13.
- i_req and d_req (d_wr=0, d_addr=0x2000) at T -> D fill completes, d_done at T+12; I fill issues from T+14; never both valids asserted together.
- d_req, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> single cycle with mem_en=1, mem_wr=1 and d_done. Then a D fill at 0x0046 -> idx 0 returns 0xBEEF.
- rst asserted in the cycle idx 3 returns -> next cycle busy=0, and no further fill_valid or done although memory still returns data.
- i_addr=0xFFFE -> base 0xFFF0, last issue 0xFFFE with no wrap. i_req held across i_done -> second fill starts after exactly one IDLE cycle.
